// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle main control unit for the RV32I-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and the 2-bit aluOp
// consumed by the ALU control stage, and counts retired instructions.
module main_control_fsm #(
   parameter int unsigned USE_MEM_READY = 1,
   parameter int unsigned RET_CNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opcode,
   input  logic                 mem_ready,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 i_or_d,
   output logic                 alu_src_b,
   output logic [1:0]           aluOp,
   output logic                 mem_to_reg,
   output logic                 reg_write,
   output logic                 illegal_op,
   output logic [RET_CNT_W-1:0] instr_retired,
   output logic [3:0]           state
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      EXEC_I    = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   state_t cur, nxt;

   logic       rdy;
   logic       op_r, op_lw, op_sw, op_beq, op_addi;
   logic       retire;
   logic       illegal_nxt;
   logic [1:0] hold_aluop;
   logic       hold_srcb;

   // raw enables before the reset gate
   logic ir_write_c, pc_write_c, pc_write_cond_c;
   logic mem_read_c, mem_write_c, reg_write_c;

   // Effective handshake: with USE_MEM_READY=0 memory always completes in one cycle
   generate
      if (USE_MEM_READY != 0) begin : g_rdy
         assign rdy = mem_ready;
      end else begin : g_no_rdy
         assign rdy = 1'b1;
      end
   endgenerate

   // Opcode class decode
   always_comb begin
      op_r    = (opcode == OP_R);
      op_lw   = (opcode == OP_LW);
      op_sw   = (opcode == OP_SW);
      op_beq  = (opcode == OP_BEQ);
      op_addi = (opcode == OP_ADDI);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= FETCH;
      end else begin
         cur <= nxt;
      end
   end

   // Next-state, retire strobe, illegal detect and state-decoded outputs
   always_comb begin
      nxt             = FETCH;
      retire          = 1'b0;
      illegal_nxt     = 1'b0;
      ir_write_c      = 1'b0;
      pc_write_c      = 1'b0;
      pc_write_cond_c = 1'b0;
      mem_read_c      = 1'b0;
      mem_write_c     = 1'b0;
      reg_write_c     = 1'b0;
      i_or_d          = 1'b0;
      alu_src_b       = 1'b0;
      aluOp           = 2'b00;
      mem_to_reg      = 1'b0;

      case (cur)
         FETCH: begin
            mem_read_c = 1'b1;
            ir_write_c = rdy;
            pc_write_c = rdy;
            nxt        = rdy ? DECODE : FETCH;
         end
         DECODE: begin
            // ALU control registers its output, so aluOp is driven a cycle early here
            if (op_lw || op_sw) begin
               aluOp     = 2'b00;
               alu_src_b = 1'b1;
               nxt       = MEM_ADDR;
            end else if (op_r) begin
               aluOp     = 2'b10;
               alu_src_b = 1'b0;
               nxt       = EXEC_R;
            end else if (op_addi) begin
               aluOp     = 2'b11;
               alu_src_b = 1'b1;
               nxt       = EXEC_I;
            end else if (op_beq) begin
               aluOp     = 2'b01;
               alu_src_b = 1'b0;
               nxt       = BRANCH;
            end else begin
               illegal_nxt = 1'b1;
               nxt         = FETCH;
            end
         end
         MEM_ADDR: begin
            aluOp     = 2'b00;
            alu_src_b = 1'b1;
            if (op_lw) begin
               nxt = MEM_READ;
            end else if (op_sw) begin
               nxt = MEM_WRITE;
            end else begin
               nxt = FETCH;
            end
         end
         MEM_READ: begin
            mem_read_c = 1'b1;
            i_or_d     = 1'b1;
            nxt        = rdy ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            reg_write_c = 1'b1;
            mem_to_reg  = 1'b1;
            retire      = 1'b1;
            nxt         = FETCH;
         end
         MEM_WRITE: begin
            mem_write_c = 1'b1;
            i_or_d      = 1'b1;
            retire      = rdy;
            nxt         = rdy ? FETCH : MEM_WRITE;
         end
         EXEC_R: begin
            aluOp     = 2'b10;
            alu_src_b = 1'b0;
            nxt       = ALU_WB;
         end
         EXEC_I: begin
            aluOp     = 2'b11;
            alu_src_b = 1'b1;
            nxt       = ALU_WB;
         end
         ALU_WB: begin
            // ALU settings come from the hold register, not opcode
            aluOp       = hold_aluop;
            alu_src_b   = hold_srcb;
            reg_write_c = 1'b1;
            mem_to_reg  = 1'b0;
            retire      = 1'b1;
            nxt         = FETCH;
         end
         BRANCH: begin
            aluOp           = 2'b01;
            alu_src_b       = 1'b0;
            pc_write_cond_c = 1'b1;
            retire          = 1'b1;
            nxt             = FETCH;
         end
         default: begin
            nxt = FETCH;
         end
      endcase
   end

   // Enables are forced low for as long as reset is asserted
   always_comb begin
      ir_write      = ir_write_c      & ~reset;
      pc_write      = pc_write_c      & ~reset;
      pc_write_cond = pc_write_cond_c & ~reset;
      mem_read      = mem_read_c      & ~reset;
      mem_write     = mem_write_c     & ~reset;
      reg_write     = reg_write_c     & ~reset;
   end

   // Hold the EXEC ALU settings so ALU_WB keeps driving them without re-decoding opcode
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_aluop <= 2'b00;
         hold_srcb  <= 1'b0;
      end else if (cur == EXEC_R) begin
         hold_aluop <= 2'b10;
         hold_srcb  <= 1'b0;
      end else if (cur == EXEC_I) begin
         hold_aluop <= 2'b11;
         hold_srcb  <= 1'b1;
      end
   end

   // One-cycle registered illegal-opcode pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= illegal_nxt;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^RET_CNT_W
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_retired <= '0;
      end else if (retire) begin
         instr_retired <= instr_retired + RET_CNT_W'(1);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: directed-vector bench for main_control_fsm.
// A second instance with a 2-bit retire counter shares all inputs to check wrap-around.
module tb_main_control_fsm;

   // {ir_write, pc_write, pc_write_cond, mem_read, mem_write, i_or_d, alu_src_b, aluOp[1:0], mem_to_reg, reg_write}
   localparam logic [10:0] V_ZERO    = 11'b00000000000;
   localparam logic [10:0] V_FETCH_R = 11'b11010000000;
   localparam logic [10:0] V_FETCH_W = 11'b00010000000;
   localparam logic [10:0] V_DEC_R   = 11'b00000001000;
   localparam logic [10:0] V_DEC_M   = 11'b00000010000;
   localparam logic [10:0] V_DEC_I   = 11'b00000011100;
   localparam logic [10:0] V_DEC_B   = 11'b00000000100;
   localparam logic [10:0] V_BRANCH  = 11'b00100000100;
   localparam logic [10:0] V_AWB_R   = 11'b00000001001;
   localparam logic [10:0] V_AWB_I   = 11'b00000011101;
   localparam logic [10:0] V_MRD     = 11'b00010100000;
   localparam logic [10:0] V_MWB     = 11'b00000000011;
   localparam logic [10:0] V_MWR     = 11'b00001100000;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   logic        clk;
   logic        reset;
   logic [6:0]  opcode;
   logic        mem_ready;

   logic        ir_write, pc_write, pc_write_cond, mem_read, mem_write, i_or_d;
   logic        alu_src_b, mem_to_reg, reg_write, illegal_op;
   logic [1:0]  aluOp;
   logic [31:0] instr_retired;
   logic [3:0]  state;

   logic        ir_write2, pc_write2, pc_write_cond2, mem_read2, mem_write2, i_or_d2;
   logic        alu_src_b2, mem_to_reg2, reg_write2, illegal_op2;
   logic [1:0]  aluOp2;
   logic [1:0]  instr_retired2;
   logic [3:0]  state2;

   logic [10:0] vec;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

   main_control_fsm #(.USE_MEM_READY(1), .RET_CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .alu_src_b(alu_src_b), .aluOp(aluOp), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .illegal_op(illegal_op),
      .instr_retired(instr_retired), .state(state)
   );

   main_control_fsm #(.USE_MEM_READY(1), .RET_CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .ir_write(ir_write2), .pc_write(pc_write2), .pc_write_cond(pc_write_cond2),
      .mem_read(mem_read2), .mem_write(mem_write2), .i_or_d(i_or_d2),
      .alu_src_b(alu_src_b2), .aluOp(aluOp2), .mem_to_reg(mem_to_reg2),
      .reg_write(reg_write2), .illegal_op(illegal_op2),
      .instr_retired(instr_retired2), .state(state2)
   );

   assign vec = {ir_write, pc_write, pc_write_cond, mem_read, mem_write, i_or_d,
                 alu_src_b, aluOp, mem_to_reg, reg_write};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s.%s: observed=%0h expected=%0h", tag, field, obs, exp);
      end
   endtask

   // Inputs are driven at the negedge before calling; outputs are checked 1 time unit later.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [10:0] v,
                      input int unsigned cnt, input logic ill);
      logic [1:0] cnt2;
      #1;
      cnt2 = 2'(cnt % 4);
      check(tag, "state",   {28'd0, state}, {28'd0, st});
      check(tag, "outputs", {21'd0, vec}, {21'd0, v});
      check(tag, "retired", instr_retired, cnt);
      check(tag, "retired_w2", {30'd0, instr_retired2}, {30'd0, cnt2});
      check(tag, "illegal", {31'd0, illegal_op}, {31'd0, ill});
      check(tag, "state_w2", {28'd0, state2}, {28'd0, st});
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      opcode    = OP_R;
      mem_ready = 1'b1;
      @(negedge clk);
      cyc("rst_init", 4'd0, V_ZERO, 0, 1'b0);

      // Start an R-type, then reset it from EXEC_R for two cycles
      reset = 1'b0;
      cyc("abort_f",  4'd0, V_FETCH_R, 0, 1'b0);
      cyc("abort_d",  4'd1, V_DEC_R,   0, 1'b0);
      reset = 1'b1;
      cyc("abort_ex", 4'd6, V_DEC_R,   0, 1'b0);
      cyc("rst_c1",   4'd0, V_ZERO,    0, 1'b0);
      cyc("rst_c2",   4'd0, V_ZERO,    0, 1'b0);
      reset = 1'b0;

      // R-type with mem_ready always high
      cyc("r_fetch", 4'd0, V_FETCH_R, 0, 1'b0);
      cyc("r_dec",   4'd1, V_DEC_R,   0, 1'b0);
      cyc("r_exec",  4'd6, V_DEC_R,   0, 1'b0);
      cyc("r_wb",    4'd8, V_AWB_R,   0, 1'b0);

      // lw: two wait cycles in FETCH, one in MEM_READ
      opcode    = OP_LW;
      mem_ready = 1'b0;
      cyc("lw_fw1",  4'd0, V_FETCH_W, 1, 1'b0);
      cyc("lw_fw2",  4'd0, V_FETCH_W, 1, 1'b0);
      mem_ready = 1'b1;
      cyc("lw_f",    4'd0, V_FETCH_R, 1, 1'b0);
      cyc("lw_dec",  4'd1, V_DEC_M,   1, 1'b0);
      cyc("lw_addr", 4'd2, V_DEC_M,   1, 1'b0);
      mem_ready = 1'b0;
      cyc("lw_rdw",  4'd3, V_MRD,     1, 1'b0);
      mem_ready = 1'b1;
      cyc("lw_rd",   4'd3, V_MRD,     1, 1'b0);
      cyc("lw_wb",   4'd4, V_MWB,     1, 1'b0);

      // sw then beq
      opcode = OP_SW;
      cyc("sw_f",    4'd0, V_FETCH_R, 2, 1'b0);
      cyc("sw_dec",  4'd1, V_DEC_M,   2, 1'b0);
      cyc("sw_addr", 4'd2, V_DEC_M,   2, 1'b0);
      cyc("sw_wr",   4'd5, V_MWR,     2, 1'b0);
      opcode = OP_BEQ;
      cyc("beq_f",   4'd0, V_FETCH_R, 3, 1'b0);
      cyc("beq_dec", 4'd1, V_DEC_B,   3, 1'b0);
      cyc("beq_br",  4'd9, V_BRANCH,  3, 1'b0);

      // Illegal opcode: back to FETCH, one-cycle pulse, count unchanged
      opcode = OP_BAD;
      cyc("ill_f",   4'd0, V_FETCH_R, 4, 1'b0);
      cyc("ill_dec", 4'd1, V_ZERO,    4, 1'b0);
      opcode = OP_ADDI;
      cyc("ill_pls", 4'd0, V_FETCH_R, 4, 1'b1);
      reset = 1'b1;
      cyc("ill_end", 4'd1, V_DEC_I,   4, 1'b0);
      cyc("rst_3",   4'd0, V_ZERO,    0, 1'b0);
      reset = 1'b0;

      // Five addi: 2-bit counter sees 1,2,3,0,1
      for (int k = 0; k < 5; k++) begin
         cyc("addi_f",   4'd0, V_FETCH_R, k, 1'b0);
         cyc("addi_dec", 4'd1, V_DEC_I,   k, 1'b0);
         cyc("addi_ex",  4'd7, V_DEC_I,   k, 1'b0);
         cyc("addi_wb",  4'd8, V_AWB_I,   k, 1'b0);
      end
      cyc("addi_end", 4'd0, V_FETCH_R, 5, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
